instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage and IF/ID pipeline register for the MIPS datapath. It owns the PC and fetches words from instruction memory over a req/ack handshake. It holds the fetched word and PC+4 in the IF/ID register, whose opcode field (bits 31:26) drives `instr_op` of the main control unit. It handles pipeline stalls with a one-entry skid buffer, and handles branch redirects, including a redirect that arrives while a memory request is still outstanding.

## Interface
Clock is `clk`. Reset is `rst`: synchronous, active-high.

Parameters:
- `PC_RESET`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  synchronous active-high reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address (word-aligned)
- `imem_ack`  in  1  memory accepted the request; `imem_rdata` is valid in this cycle
- `imem_rdata`  in  32  instruction word
- `stall`  in  1  hazard unit: hold IF/ID and do not advance the PC
- `branch_taken`  in  1  one-cycle redirect pulse from the branch-resolution logic
- `branch_target`  in  32  redirect address; bits [1:0] are ignored and treated as 0
- `ifid_valid`  out  1  IF/ID holds a real instruction
- `ifid_instr`  out  32  IF/ID instruction word
- `ifid_pc_plus4`  out  32  IF/ID PC+4
- `ifid_opcode`  out  6  `ifid_instr[31:26]`; connects to the control unit's `instr_op`

## Operation
- **Handshake rule.** While `imem_req`=1 and `imem_ack`=0, `imem_addr` is held stable. A transfer completes in a cycle with `imem_req`&&`imem_ack`. `imem_req`=0 in any cycle where `rst`=1.
- **FSM states:**
  - **FETCH**: `imem_req`=1, `imem_addr`=pc.
  - **HOLD**: `imem_req`=0; the skid buffer holds a word that could not enter IF/ID because of a stall.
  - **DRAIN**: `imem_req`=1, `imem_addr`=the old pc; waiting for ack of a now wrong-path request.
- **Priority:** `rst` > `branch_taken` > `stall`.
- **FETCH, `branch_taken`=1:**
  - If `imem_ack`=1 or no request is outstanding: pc<=target, stay in FETCH, and any returned data is discarded.
  - Otherwise: latch the target into `pend_pc`, go to DRAIN.
  - IF/ID is flushed either way.
- **FETCH, ack && !stall:** IF/ID<={valid=1, rdata, pc+4}; pc<=pc+4.
- **FETCH, ack && stall:** buffer<=rdata; go to HOLD; IF/ID is unchanged.
- **FETCH, no ack:** if !stall, IF/ID becomes a bubble (valid=0, instr=0); if stall, IF/ID is held.
- **HOLD:**
  - `branch_taken`: discard the buffer, pc<=target, flush IF/ID, go to FETCH.
  - !stall: IF/ID<={1, buffer, pc+4}; pc<=pc+4; go to FETCH.
  - Otherwise: stay in HOLD.
- **DRAIN:**
  - A new `branch_taken` overwrites `pend_pc`.
  - On ack: discard the data, pc<=`pend_pc` (or the new target if `branch_taken` is asserted in the same cycle), go to FETCH.
  - IF/ID stays a bubble throughout DRAIN; `stall` has no effect on it.
- **Flush and bubble encoding:** valid=0, instr=32'h0000_0000 (MIPS nop), pc_plus4=0.
- **Arithmetic:** pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). The PC is always word-aligned.

## Timing
- **Reset.** After a rising edge with `rst`=1:
  - pc=`PC_RESET`, state=FETCH, buffer=0, `pend_pc`=0.
  - `ifid_valid`=0, `ifid_instr`=0, `ifid_pc_plus4`=0, `ifid_opcode`=0.
  - `imem_addr`=`PC_RESET`.
  - `imem_req`=0 while `rst` is high, then 1 in the first cycle with `rst` low.
- **Reset mid-transfer:** state is abandoned with no drain. The memory must tolerate a request being withdrawn by reset.
- **Latency:** ack in cycle N -> `ifid_valid`=1 in cycle N+1. With a zero-wait memory (ack tied to 1), throughput is 1 instruction/cycle.
- **Redirect:** `branch_taken` in cycle N -> `imem_addr`=target in cycle N+1 if no request is pending. Otherwise the target appears in the cycle after the draining ack.
- **Stall release from HOLD:** the buffered word appears in IF/ID one cycle after `stall` falls, and the next fetch request issues in that same cycle.
- **`ifid_opcode`** is combinational from the IF/ID register.

## Test plan
- **Reset and straight-line fetch.** Reset with `PC_RESET`=0x0040_0000, ack=1, rdata=0x8C01_0004 -> `imem_addr` 0x0040_0000, 0x0040_0004, ... on consecutive cycles. The first `ifid_instr`=0x8C01_0004 with `ifid_pc_plus4`=0x0040_0004 and `ifid_opcode`=6'b100011.
- **Wait states.** Ack delayed 3 cycles -> `imem_addr` stable for all 4 cycles, `ifid_valid`=0 for 3 cycles then 1, and the PC advances exactly once.
- **Stall on ack.** `stall`=1 in the ack cycle for 2 cycles -> IF/ID unchanged, `imem_req`=0 in HOLD. The buffered word reaches IF/ID one cycle after `stall` falls, with no word lost or duplicated.
- **Redirect cases.**
  - `branch_taken` with target 0x0000_0103 in a free cycle -> next `imem_addr`=0x0000_0100 and IF/ID flushed.
  - The same pulse during a pending 2-cycle request -> the old address is held until ack, that data is discarded, then 0x0000_0100 is fetched.
- **Wrap and simultaneity.**
  - pc=0xFFFF_FFFC fetched -> `ifid_pc_plus4`=0, next fetch address 0.
  - `branch_taken` and `stall` both asserted -> IF/ID flushed, not held.
  - `rst` during HOLD -> outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS fetch stage with IF/ID register, one-entry skid buffer
// and draining of a wrong-path request after a redirect.
module instr_fetch #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc_plus4,
   output logic [5:0]  ifid_opcode
);
   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
   state_t      r_state, w_next;
   logic [31:0] r_pc, r_buf, r_pend_pc, r_instr, r_pc4;
   logic        r_valid;
   logic [31:0] w_pc, w_buf, w_pend, w_instr, w_pc4, w_tgt, w_pc_inc;
   logic        w_valid;
   assign w_tgt    = branch_target & ~32'd3;
   assign w_pc_inc = r_pc + 32'd4;
   always_comb begin
      w_next  = r_state;
      w_pc    = r_pc;
      w_buf   = r_buf;
      w_pend  = r_pend_pc;
      w_valid = r_valid;
      w_instr = r_instr;
      w_pc4   = r_pc4;
      case (r_state)
         FETCH: begin
            if (branch_taken) begin
               {w_valid, w_instr, w_pc4} = '0;
               if (imem_ack) w_pc = w_tgt;
               else begin
                  w_pend = w_tgt;
                  w_next = DRAIN;
               end
            end else if (imem_ack && !stall) begin
               w_valid = 1'b1;
               w_instr = imem_rdata;
               w_pc4   = w_pc_inc;
               w_pc    = w_pc_inc;
            end else if (imem_ack) begin
               w_buf  = imem_rdata;
               w_next = HOLD;
            end else if (!stall) {w_valid, w_instr, w_pc4} = '0;
         end
         HOLD: begin
            if (branch_taken) begin
               {w_valid, w_instr, w_pc4} = '0;
               w_pc   = w_tgt;
               w_next = FETCH;
            end else if (!stall) begin
               w_valid = 1'b1;
               w_instr = r_buf;
               w_pc4   = w_pc_inc;
               w_pc    = w_pc_inc;
               w_next  = FETCH;
            end
         end
         DRAIN: begin
            // The address stays on the old pc until the wrong-path word is acked.
            {w_valid, w_instr, w_pc4} = '0;
            if (branch_taken) w_pend = w_tgt;
            if (imem_ack) begin
               w_pc   = branch_taken ? w_tgt : r_pend_pc;
               w_next = FETCH;
            end
         end
         default: w_next = FETCH;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= FETCH;
         r_pc      <= PC_RESET;
         r_buf     <= '0;
         r_pend_pc <= '0;
         r_valid   <= 1'b0;
         r_instr   <= '0;
         r_pc4     <= '0;
      end else begin
         r_state   <= w_next;
         r_pc      <= w_pc;
         r_buf     <= w_buf;
         r_pend_pc <= w_pend;
         r_valid   <= w_valid;
         r_instr   <= w_instr;
         r_pc4     <= w_pc4;
      end
   end
   assign imem_req      = !rst && (r_state != HOLD);
   assign imem_addr     = r_pc;
   assign ifid_valid    = r_valid;
   assign ifid_instr    = r_instr;
   assign ifid_pc_plus4 = r_pc4;
   assign ifid_opcode   = r_instr[31:26];
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus a randomized run checked against a
// program-order model of which words must reach IF/ID.
module tb_instr_fetch;
   localparam logic [31:0] PCR = 32'h0040_0000;
   logic        clk = 1'b0;
   logic        rst, imem_ack, stall, branch_taken, use_f;
   logic [31:0] rdata_v, branch_target;
   logic        imem_req, ifid_valid;
   logic [31:0] imem_addr, imem_rdata, ifid_instr, ifid_pc_plus4;
   logic [5:0]  ifid_opcode;
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign imem_rdata = use_f ? f(imem_addr) : rdata_v;

   instr_fetch #(.PC_RESET(PCR)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
      .ifid_pc_plus4(ifid_pc_plus4), .ifid_opcode(ifid_opcode)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      branch_target = '0; rdata_v = '0; use_f = 1'b0;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_ack = 1'b1; stall = 1'b0; branch_taken = 1'b0;
      branch_target = '0; rdata_v = 32'hDEAD_BEEF; use_f = 1'b0;
      tick(); tick();
      chk("reset_req", {31'd0, imem_req}, 32'd0);
      chk("reset_addr", imem_addr, PCR);
      chk("reset_valid", {31'd0, ifid_valid}, 32'd0);
      chk("reset_instr", ifid_instr, 32'd0);
      chk("reset_pc4", ifid_pc_plus4, 32'd0);
      chk("reset_opcode", {26'd0, ifid_opcode}, 32'd0);
      rst = 1'b0;
      #1;
      chk("reset_req_release", {31'd0, imem_req}, 32'd1);
   endtask

   task automatic test_straight();
      do_reset();
      imem_ack = 1'b1; rdata_v = 32'h8C01_0004;
      chk("straight_addr0", imem_addr, PCR);
      tick();
      chk("straight_instr", ifid_instr, 32'h8C01_0004);
      chk("straight_opcode", {26'd0, ifid_opcode}, 32'h23);
      for (int i = 1; i < 5; i++) begin
         chk("straight_addr", imem_addr, PCR + 32'(4 * i));
         chk("straight_valid", {31'd0, ifid_valid}, 32'd1);
         chk("straight_pc4", ifid_pc_plus4, PCR + 32'(4 * i));
         tick();
      end
   endtask

   task automatic test_wait_states();
      do_reset();
      rdata_v = 32'h0000_1111;
      for (int i = 0; i < 3; i++) begin
         chk("wait_addr", imem_addr, PCR);
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         tick();
         chk("wait_valid", {31'd0, ifid_valid}, 32'd0);
      end
      imem_ack = 1'b1;
      chk("wait_addr_ack", imem_addr, PCR);
      tick();
      imem_ack = 1'b0;
      #1;
      chk("wait_valid_after", {31'd0, ifid_valid}, 32'd1);
      chk("wait_pc4", ifid_pc_plus4, PCR + 32'd4);
      chk("wait_addr_next", imem_addr, PCR + 32'd4);
   endtask

   task automatic test_stall_on_ack();
      do_reset();
      imem_ack = 1'b1; rdata_v = 32'hAAAA_0001;
      tick();
      rdata_v = 32'hBBBB_0002; stall = 1'b1;
      tick();
      chk("stall_hold_instr", ifid_instr, 32'hAAAA_0001);
      chk("stall_hold_req", {31'd0, imem_req}, 32'd0);
      imem_ack = 1'b0;
      tick();
      chk("stall_hold2_instr", ifid_instr, 32'hAAAA_0001);
      chk("stall_hold2_pc4", ifid_pc_plus4, PCR + 32'd4);
      chk("stall_hold2_req", {31'd0, imem_req}, 32'd0);
      stall = 1'b0;
      tick();
      chk("stall_rel_instr", ifid_instr, 32'hBBBB_0002);
      chk("stall_rel_pc4", ifid_pc_plus4, PCR + 32'd8);
      chk("stall_rel_req", {31'd0, imem_req}, 32'd1);
      chk("stall_rel_addr", imem_addr, PCR + 32'd8);
      imem_ack = 1'b1; rdata_v = 32'hCCCC_0003;
      tick();
      chk("stall_next_instr", ifid_instr, 32'hCCCC_0003);
      chk("stall_next_pc4", ifid_pc_plus4, PCR + 32'd12);
   endtask

   task automatic test_redirect_free();
      do_reset();
      imem_ack = 1'b1; rdata_v = 32'h1234_0000;
      tick();
      branch_taken = 1'b1; branch_target = 32'h0000_0103;
      tick();
      branch_taken = 1'b0;
      #1;
      chk("redir_addr", imem_addr, 32'h0000_0100);
      chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
      chk("redir_instr", ifid_instr, 32'd0);
      chk("redir_pc4", ifid_pc_plus4, 32'd0);
      rdata_v = 32'h5555_0000;
      tick();
      chk("redir_next_instr", ifid_instr, 32'h5555_0000);
      chk("redir_next_pc4", ifid_pc_plus4, 32'h0000_0104);
   endtask

   task automatic test_redirect_pending();
      do_reset();
      tick();
      branch_taken = 1'b1; branch_target = 32'h0000_0103;
      chk("drain_addr0", imem_addr, PCR);
      tick();
      branch_taken = 1'b0;
      #1;
      chk("drain_addr1", imem_addr, PCR);
      chk("drain_req1", {31'd0, imem_req}, 32'd1);
      chk("drain_valid1", {31'd0, ifid_valid}, 32'd0);
      stall = 1'b1;
      tick();
      chk("drain_addr2", imem_addr, PCR);
      imem_ack = 1'b1; rdata_v = 32'hBAD0_BAD0;
      tick();
      imem_ack = 1'b0; stall = 1'b0;
      #1;
      chk("drain_target", imem_addr, 32'h0000_0100);
      chk("drain_valid3", {31'd0, ifid_valid}, 32'd0);
      imem_ack = 1'b1; rdata_v = 32'h600D_0000;
      tick();
      chk("drain_good_instr", ifid_instr, 32'h600D_0000);
      chk("drain_good_pc4", ifid_pc_plus4, 32'h0000_0104);
   endtask

   task automatic test_wrap();
      do_reset();
      imem_ack = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
      tick();
      branch_taken = 1'b0;
      #1;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      rdata_v = 32'h0800_0000;
      tick();
      chk("wrap_valid", {31'd0, ifid_valid}, 32'd1);
      chk("wrap_pc4", ifid_pc_plus4, 32'd0);
      chk("wrap_next_addr", imem_addr, 32'd0);
   endtask

   task automatic test_branch_stall();
      do_reset();
      imem_ack = 1'b1; rdata_v = 32'h7777_0000;
      tick();
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0200;
      tick();
      stall = 1'b0; branch_taken = 1'b0;
      #1;
      chk("brstall_valid", {31'd0, ifid_valid}, 32'd0);
      chk("brstall_instr", ifid_instr, 32'd0);
      chk("brstall_addr", imem_addr, 32'h0000_0200);
   endtask

   task automatic test_reset_in_hold();
      do_reset();
      imem_ack = 1'b1; rdata_v = 32'h1111_0000;
      tick();
      stall = 1'b1;
      tick();
      chk("rsthold_req_pre", {31'd0, imem_req}, 32'd0);
      rst = 1'b1;
      tick();
      chk("rsthold_valid", {31'd0, ifid_valid}, 32'd0);
      chk("rsthold_instr", ifid_instr, 32'd0);
      chk("rsthold_pc4", ifid_pc_plus4, 32'd0);
      chk("rsthold_addr", imem_addr, PCR);
      chk("rsthold_req", {31'd0, imem_req}, 32'd0);
      rst = 1'b0; stall = 1'b0;
      #1;
      chk("rsthold_req_rel", {31'd0, imem_req}, 32'd1);
   endtask

   task automatic test_random();
      logic [31:0] exp_pc, p_addr, p_instr, p_pc4;
      logic        p_req, p_ack, p_stall, p_br, p_valid;
      int          n_instr = 0;
      do_reset();
      use_f = 1'b1;
      exp_pc = PCR;
      for (int c = 0; c < 3000; c++) begin
         imem_ack      = ($urandom_range(0, 9) < 6);
         stall         = ($urandom_range(0, 9) < 3);
         branch_taken  = ($urandom_range(0, 19) == 0);
         branch_target = $urandom;
         #1;
         p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
         p_stall = stall; p_br = branch_taken;
         p_valid = ifid_valid; p_instr = ifid_instr; p_pc4 = ifid_pc_plus4;
         if (p_br) exp_pc = branch_target & ~32'd3;
         tick();
         if (p_req && !p_ack) begin
            checks++;
            if (!imem_req || imem_addr !== p_addr) begin
               errors++;
               $display("FAIL rand_handshake c=%0d: req=%b addr=%h expected req=1 addr=%h", c, imem_req, imem_addr, p_addr);
            end
         end
         if (p_br || !p_stall) begin
            if (p_br || !ifid_valid) begin
               checks++;
               if (ifid_valid !== 1'b0 || ifid_instr !== 32'd0 || ifid_pc_plus4 !== 32'd0) begin
                  errors++;
                  $display("FAIL rand_bubble c=%0d: v=%b instr=%h pc4=%h expected 0/0/0", c, ifid_valid, ifid_instr, ifid_pc_plus4);
               end
            end else begin
               checks++;
               if (ifid_instr !== f(exp_pc) || ifid_pc_plus4 !== exp_pc + 32'd4) begin
                  errors++;
                  $display("FAIL rand_order c=%0d: instr=%h pc4=%h expected %h %h", c, ifid_instr, ifid_pc_plus4, f(exp_pc), exp_pc + 32'd4);
               end
               exp_pc += 32'd4;
               n_instr++;
            end
         end else begin
            checks++;
            if (ifid_valid !== p_valid || ifid_instr !== p_instr || ifid_pc_plus4 !== p_pc4) begin
               errors++;
               $display("FAIL rand_hold c=%0d: v=%b instr=%h pc4=%h expected %b %h %h", c, ifid_valid, ifid_instr, ifid_pc_plus4, p_valid, p_instr, p_pc4);
            end
         end
      end
      checks++;
      if (n_instr < 200) begin
         errors++;
         $display("FAIL rand_progress: got %0d instructions expected at least 200", n_instr);
      end
      use_f = 1'b0; imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
   endtask

   initial begin
      test_reset();
      test_straight();
      test_wait_states();
      test_stall_on_ack();
      test_redirect_free();
      test_redirect_pending();
      test_wrap();
      test_branch_stall();
      test_reset_in_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
